// File: rtl/sdm_alloc_pkg.sv
// Shared types and helpers for the SDM output-port allocators.
// Holds the sub-channel index type, the size limits and the lowest-free-index encoder.
package sdm_alloc_pkg;

   typedef logic [1:0] sc_idx_t;

   localparam int MAX_RN = 5;
   localparam int MAX_M  = 4;

   // Returns the index of the lowest set bit in free_vec (0 when none is set).
   function automatic sc_idx_t lowest_free(input logic [MAX_M-1:0] free_vec);
      sc_idx_t idx;
      idx = '0;
      for (int s = MAX_M - 1; s >= 0; s--) begin
         if (free_vec[s]) begin
            idx = sc_idx_t'(s);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/sdm_rr_arb.sv
// RN-input round-robin picker.
// The winner is the first requester at or after the pointer, wrapping modulo RN.
// The pointer moves to winner+1 only when the caller accepts the pick (adv).
module sdm_rr_arb #(
   parameter int RN = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [RN-1:0] req,
   input  logic          adv,
   output logic [RN-1:0] win,
   output logic          valid
);

   localparam int PW = (RN > 1) ? $clog2(RN) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] win_idx;

   // Scan from the pointer and stop at the first active request.
   always_comb begin : pick
      int idx;
      idx     = 0;
      win     = '0;
      valid   = 1'b0;
      win_idx = '0;
      for (int k = 0; k < RN; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= RN) begin
            idx = idx - RN;
         end
         if (!valid && req[idx]) begin
            valid    = 1'b1;
            win[idx] = 1'b1;
            win_idx  = PW'(idx);
         end
      end
   end

   // Advance the pointer past the winner whenever its pick is consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (adv && valid) begin
         ptr_q <= (win_idx == PW'(RN - 1)) ? '0 : win_idx + 1'b1;
      end
   end

endmodule

// File: rtl/sdm_out_alloc.sv
// Output-port sub-channel allocator for the SDM router.
// Grants free sub-channels to requesting inputs in round-robin order, tracks
// ownership until tail flit (or protocol violation) and drives the crossbar column.
// Optional feature: define SDM_ALLOC_TIMEOUT_EN for per-sub-channel watchdogs that
// force-release a grant whose counter reaches all-ones.
module sdm_out_alloc
   import sdm_alloc_pkg::*;
#(
   parameter int RN = 4,
   parameter int M  = 2,
   parameter int TW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [RN-1:0]   req,
   input  logic [RN-1:0]   eof,
   output logic [RN-1:0]   gnt,
   output logic [RN*2-1:0] gsc,
   output logic [M*RN-1:0] xsel,
   output logic [M-1:0]    busy,
   output logic            err
);

   logic [RN-1:0]   gnt_q,  gnt_d;
   logic [RN*2-1:0] gsc_q,  gsc_d;
   logic [M*RN-1:0] xsel_q, xsel_d;
   logic [M-1:0]    busy_q, busy_d;
   logic            err_q,  err_d;

   logic [RN-1:0]    cand;
   logic [RN-1:0]    win;
   logic             win_valid;
   logic             free_any;
   logic             grant_en;
   logic [MAX_M-1:0] free_ext;
   sc_idx_t          free_idx;
   logic [M-1:0]     alloc_ch;
   logic [M-1:0]     timeout_ch;
   logic [RN-1:0]    timeout_in;
   logic [RN-1:0]    rel_in;
   logic [M-1:0]     rel_ch;

   assign cand     = req & ~gnt_q;
   assign free_any = |(~busy_q);
   assign grant_en = win_valid & free_any;

   sdm_rr_arb #(
      .RN (RN)
   ) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (cand),
      .adv   (free_any),
      .win   (win),
      .valid (win_valid)
   );

   // Only channels already free at the start of the cycle are offered to the winner.
   always_comb begin
      free_ext          = '0;
      free_ext[M-1:0]   = ~busy_q;
      free_idx          = lowest_free(free_ext);
      alloc_ch          = '0;
      for (int s = 0; s < M; s++) begin
         alloc_ch[s] = grant_en && (free_idx == sc_idx_t'(s));
      end
   end

`ifdef SDM_ALLOC_TIMEOUT_EN
   logic [TW-1:0] wd_q [M];

   // Watchdog restarts at allocation and counts every cycle the channel stays busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < M; s++) begin
            wd_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < M; s++) begin
            if (alloc_ch[s]) begin
               wd_q[s] <= '0;
            end else if (busy_q[s]) begin
               wd_q[s] <= wd_q[s] + 1'b1;
            end
         end
      end
   end

   // An all-ones watchdog on a busy channel forces its release on the next edge.
   always_comb begin
      timeout_ch = '0;
      for (int s = 0; s < M; s++) begin
         timeout_ch[s] = busy_q[s] & (&wd_q[s]);
      end
   end
`else
   assign timeout_ch = '0;
`endif

   // Work out which inputs and which channels give up ownership this cycle, and flag violations.
   always_comb begin
      timeout_in = '0;
      for (int s = 0; s < M; s++) begin
         if (timeout_ch[s]) begin
            timeout_in = timeout_in | xsel_q[s*RN +: RN];
         end
      end
      rel_in = gnt_q & (eof | ~req | timeout_in);
      rel_ch = '0;
      for (int s = 0; s < M; s++) begin
         rel_ch[s] = |(xsel_q[s*RN +: RN] & rel_in);
      end
      err_d = (|(eof & ~gnt_q)) | (|(gnt_q & ~req & ~eof)) | (|timeout_ch);
   end

   // Next ownership table: clear released entries, then record the single new grant.
   always_comb begin
      gnt_d  = gnt_q & ~rel_in;
      gsc_d  = gsc_q;
      busy_d = busy_q;
      xsel_d = xsel_q;
      for (int i = 0; i < RN; i++) begin
         if (rel_in[i]) begin
            gsc_d[2*i +: 2] = '0;
         end
         if (grant_en && win[i]) begin
            gnt_d[i]        = 1'b1;
            gsc_d[2*i +: 2] = free_idx;
         end
      end
      for (int s = 0; s < M; s++) begin
         if (rel_ch[s]) begin
            busy_d[s]          = 1'b0;
            xsel_d[s*RN +: RN] = '0;
         end
         if (alloc_ch[s]) begin
            busy_d[s]          = 1'b1;
            xsel_d[s*RN +: RN] = win;
         end
      end
   end

   // All outputs are registered so nothing on req/eof reaches them combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q  <= '0;
         gsc_q  <= '0;
         xsel_q <= '0;
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         gnt_q  <= gnt_d;
         gsc_q  <= gsc_d;
         xsel_q <= xsel_d;
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign gnt  = gnt_q;
   assign gsc  = gsc_q;
   assign xsel = xsel_q;
   assign busy = busy_q;
   assign err  = err_q;

endmodule

// File: tb/tb_sdm_out_alloc.sv
// Directed bench for sdm_out_alloc with RN=4, M=2, TW=4.
// Every check compares the packed output vector {gnt, gsc, busy, xsel, err}
// against a hand-computed value.
module tb_sdm_out_alloc;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] eof;
   logic [3:0] gnt;
   logic [7:0] gsc;
   logic [7:0] xsel;
   logic [1:0] busy;
   logic       err;

   logic [22:0] obs;
   logic [22:0] exp_v;
   int          checks;
   int          fails;

   assign obs = {gnt, gsc, busy, xsel, err};

   sdm_out_alloc #(
      .RN (4),
      .M  (2),
      .TW (4)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .eof  (eof),
      .gnt  (gnt),
      .gsc  (gsc),
      .xsel (xsel),
      .busy (busy),
      .err  (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req = 4'b1111;
      eof = 4'b0000;
      tick;
      tick;
      exp_v = {4'b0000, 8'h00, 2'b00, 8'h00, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL reset_hold: got %b expected %b", obs, exp_v);
         fails++;
      end
      rst = 1'b0;
      tick;
      exp_v = {4'b0001, 8'b0000_0000, 2'b01, 8'b0000_0001, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL first_grant: got %b expected %b", obs, exp_v);
         fails++;
      end
      tick;
      exp_v = {4'b0011, 8'b0000_0100, 2'b11, 8'b0010_0001, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL second_grant: got %b expected %b", obs, exp_v);
         fails++;
      end
      tick;
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL no_free_wait: got %b expected %b", obs, exp_v);
         fails++;
      end
   endtask

   task automatic test_release_reuse;
      eof = 4'b0001;
      req = 4'b1110;
      tick;
      eof = 4'b0000;
      exp_v = {4'b0010, 8'b0000_0100, 2'b10, 8'b0010_0000, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL release_eof: got %b expected %b", obs, exp_v);
         fails++;
      end
      tick;
      exp_v = {4'b0110, 8'b0000_0100, 2'b11, 8'b0010_0100, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL reuse_grant: got %b expected %b", obs, exp_v);
         fails++;
      end
   endtask

   task automatic test_stray_eof;
      eof = 4'b1000;
      tick;
      eof = 4'b0000;
      exp_v = {4'b0110, 8'b0000_0100, 2'b11, 8'b0010_0100, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL stray_eof_err: got %b expected %b", obs, exp_v);
         fails++;
      end
      tick;
      exp_v = {4'b0110, 8'b0000_0100, 2'b11, 8'b0010_0100, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL stray_eof_clear: got %b expected %b", obs, exp_v);
         fails++;
      end
   endtask

   task automatic test_simultaneous;
      eof = 4'b0110;
      req = 4'b1000;
      tick;
      eof = 4'b0000;
      exp_v = {4'b0000, 8'h00, 2'b00, 8'h00, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL dual_release: got %b expected %b", obs, exp_v);
         fails++;
      end
      tick;
      exp_v = {4'b1000, 8'h00, 2'b01, 8'b0000_1000, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL after_dual_grant: got %b expected %b", obs, exp_v);
         fails++;
      end
   endtask

   task automatic test_req_drop;
      req = 4'b1010;
      tick;
      exp_v = {4'b1010, 8'b0000_0100, 2'b11, 8'b0010_1000, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL regrant_in1: got %b expected %b", obs, exp_v);
         fails++;
      end
      req = 4'b1000;
      tick;
      exp_v = {4'b1000, 8'h00, 2'b01, 8'b0000_1000, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL req_drop_release: got %b expected %b", obs, exp_v);
         fails++;
      end
      tick;
      exp_v = {4'b1000, 8'h00, 2'b01, 8'b0000_1000, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL req_drop_err_clear: got %b expected %b", obs, exp_v);
         fails++;
      end
   endtask

   task automatic test_reset_mid_frame;
      req = 4'b1001;
      tick;
      exp_v = {4'b1001, 8'b0000_0001, 2'b11, 8'b0001_1000, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL both_busy: got %b expected %b", obs, exp_v);
         fails++;
      end
      #3;
      rst = 1'b1;
      #1;
      exp_v = {4'b0000, 8'h00, 2'b00, 8'h00, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL async_reset: got %b expected %b", obs, exp_v);
         fails++;
      end
      tick;
      rst = 1'b0;
      tick;
      exp_v = {4'b0001, 8'h00, 2'b01, 8'b0000_0001, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL pointer_reset: got %b expected %b", obs, exp_v);
         fails++;
      end
      tick;
      exp_v = {4'b1001, 8'b0100_0000, 2'b11, 8'b1000_0001, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL post_reset_second: got %b expected %b", obs, exp_v);
         fails++;
      end
   endtask

   task automatic test_hold;
      int err_cnt;
      int drop_cnt;
      err_cnt  = 0;
      drop_cnt = 0;
`ifdef SDM_ALLOC_TIMEOUT_EN
      for (int c = 0; c < 40; c++) begin
         tick;
         if (err === 1'b1) err_cnt++;
         if (busy !== 2'b11) drop_cnt++;
      end
      checks++;
      if (err_cnt == 0 || drop_cnt == 0) begin
         $display("[TB] FAIL watchdog_release: got err_pulses=%0d busy_drops=%0d expected both nonzero", err_cnt, drop_cnt);
         fails++;
      end
`else
      for (int c = 0; c < 110; c++) begin
         tick;
         if (err === 1'b1) err_cnt++;
         if (gnt !== 4'b1001) drop_cnt++;
      end
      checks++;
      if (err_cnt != 0 || drop_cnt != 0) begin
         $display("[TB] FAIL grant_persist: got err_pulses=%0d gnt_drops=%0d expected 0 and 0", err_cnt, drop_cnt);
         fails++;
      end
      exp_v = {4'b1001, 8'b0100_0000, 2'b11, 8'b1000_0001, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         $display("[TB] FAIL persist_state: got %b expected %b", obs, exp_v);
         fails++;
      end
`endif
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      rst    = 1'b1;
      req    = 4'b0000;
      eof    = 4'b0000;
      test_reset;
      test_release_reuse;
      test_stray_eof;
      test_simultaneous;
      test_req_drop;
      test_reset_mid_frame;
      test_hold;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/sdm_out_alloc.md
# sdm_out_alloc

Synchronous output-port allocator for the SDM router. It shares one output port's M spatial sub-channels among up to RN input buffers. Each input raises a routing request, is granted a free sub-channel in round-robin order, and holds that grant until its tail flit passes. It also drives the one-hot crossbar configuration for every sub-channel, and sits between the input buffers' decoded routing requests and the output crossbar column.

## Interface
Parameters:
- RN, 4, number of requesting input ports (2..5)
- M, 2, number of SDM sub-channels on this output port (1..4)
- TW, 8, watchdog counter width (used only with the timeout feature)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  RN  routing request per input; level, held until own eof
- eof  input  RN  one-cycle pulse: tail flit of input i transferred
- gnt  output  RN  input i currently owns a sub-channel
- gsc  output  RN*2  sub-channel index owned by input i; bits [2i+1:2i]; valid while gnt[i]
- xsel  output  M*RN  crossbar config; bits [s*RN +: RN] are one-hot (or zero) input selected for sub-channel s
- busy  output  M  sub-channel s allocated
- err  output  1  one-cycle pulse: protocol violation released a grant

## Operation
- Reset (async assert, sync release): gnt=0, gsc=0, xsel=0, busy=0, err=0, RR pointer=0, watchdog counters=0.
- Per cycle, at most one new allocation. Candidates are inputs with req=1 and gnt=0.
- The round-robin winner is the first candidate at or after the pointer, wrapping modulo RN.
- The winner gets the lowest-indexed sub-channel with busy=0. The pointer then moves to winner+1 (mod RN).
- If no sub-channel is free, nothing is granted and the pointer holds.
- Grant state is registered: gnt[i], gsc[i], busy[s] and xsel[s] all update together on the edge.
- Release occurs when eof[i]=1 while gnt[i]=1. Next edge: gnt[i]=0, busy[s]=0, xsel[s]=0.
- A sub-channel freed in cycle n is not reallocated in cycle n. It becomes a candidate resource in cycle n+1.
- If eof[i] arrives while gnt[i]=0, it is ignored. err pulses for 1 cycle.
- If req[i] drops while gnt[i]=1 without eof, the grant is released exactly as an eof release, and err pulses.
- Releases on different sub-channels in the same cycle are all honoured. The one allocation in that cycle is taken from channels already free.
- Invariants:
  - No sub-channel is owned by two inputs.
  - No input owns two sub-channels.
  - popcount(gnt) == popcount(busy).

## Timing
- Allocation latency: req rises before edge n, so gnt is visible after edge n (1 cycle), assuming a free channel and that the input wins arbitration.
- Release latency: eof sampled at edge n, so gnt low after edge n. A waiting requester can be granted that channel after edge n+1.
- With all RN inputs requesting continuously and M free channels, M grants are issued in M consecutive cycles.
- Worst-case wait for a requester once a channel is free is RN-1 cycles.
- All outputs come directly from flops. There is no combinational path from req or eof to any output.

## Configuration
- SDM_ALLOC_TIMEOUT_EN defined:
  - Each sub-channel has a TW-bit watchdog. It clears on allocation and increments each cycle while busy.
  - At all-ones it force-releases the sub-channel on the next edge and pulses err.
  - The watchdog restarts at allocation.
- SDM_ALLOC_TIMEOUT_EN undefined: no counters exist. Grants are held indefinitely until eof or req drop. TW is unused.

## Structure
- Shared package sdm_alloc_pkg holds:
  - the sub-channel index typedef (2 bits)
  - the constants MAX_RN=5 and MAX_M=4
  - a helper function for lowest-free-index encoding
- One sub-module, sdm_rr_arb: an RN-input round-robin picker with pointer register, parameterized on RN, with outputs win (one-hot) and valid. It also serves other allocators.
- Top level holds the ownership table, release logic, xsel/gsc encoding and the optional watchdogs.

## Test plan
- Reset with req=4'b1111, M=2: all outputs 0. After rst drops, the first edge gives gnt=0001 with gsc[0]=0, and the second edge gives gnt=0011 with gsc[1]=1. Inputs 2 and 3 wait.
- Release and reuse: eof[0] pulses at cycle 5. gnt[0]=0 after edge 5, and input 2 is granted sub-channel 0 after edge 6. The pointer now favours input 3.
- Simultaneous: eof[1] and eof[2] in the same cycle, with req[3]=1 and no free channel. Both are released in 1 cycle, and input 3 gets sub-channel 0 on the following edge.
- Protocol errors:
  - eof[3] pulsed while gnt[3]=0 gives err for 1 cycle and no state change.
  - req[1] dropped while granted gives release plus an err pulse.
- Reset mid-frame: rst asserted asynchronously with busy=11 clears all outputs immediately, without waiting for a clock edge. The pointer returns to 0.
- With SDM_ALLOC_TIMEOUT_EN and TW=4: a granted input never sends eof, so after 15 busy cycles the sub-channel is released and err pulses. Without the macro, the grant persists for more than 100 cycles.
